// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters
// and saturating hit/mispredict statistics. Lookup is combinational; update is clocked.
module branch_predictor #(
  parameter int ENTRIES  = 16,
  parameter int ADDR_W   = 32,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1,
  parameter int STAT_W   = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              lookup_en,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              update_en,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken,
  input  logic [ADDR_W-1:0] update_target,
  input  logic              update_is_branch,
  input  logic              flush,
  output logic [STAT_W-1:0] hit_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int TGT_W = ADDR_W - 2;

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_INIT);

  function automatic logic [CTR_W-1:0] ctr_step(input logic [CTR_W-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + CTR_W'(1);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] c);
    return (c == '1) ? c : c + STAT_W'(1);
  endfunction

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TGT_W-1:0] tgt_q   [ENTRIES];
  logic [CTR_W-1:0] ctr_q   [ENTRIES];

  logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [STAT_W-1:0] mis_cnt_q, mis_cnt_d;

  // Lookup
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_idx      = lookup_pc[IDX_W+1:2];
  assign lk_tag      = lookup_pc[ADDR_W-1:IDX_W+2];
  assign pred_hit    = lookup_en & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit & ctr_q[lk_idx][CTR_W-1];
  assign pred_target = pred_taken ? {tgt_q[lk_idx], 2'b00} : lookup_pc + ADDR_W'(4);

  // Update: re-derive what the table would have predicted for the resolved PC
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              old_hit;
  logic              old_taken;
  logic [ADDR_W-1:0] old_target;
  logic              mispredict;

  assign up_idx     = update_pc[IDX_W+1:2];
  assign up_tag     = update_pc[ADDR_W-1:IDX_W+2];
  assign old_hit    = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
  assign old_taken  = old_hit & ctr_q[up_idx][CTR_W-1];
  assign old_target = old_taken ? {tgt_q[up_idx], 2'b00} : update_pc + ADDR_W'(4);
  assign mispredict = update_en &
                      ((old_taken != update_taken) |
                       (update_taken & (old_target != update_target)));

  logic             wr_en;
  logic             valid_d;
  logic [TAG_W-1:0] tag_d;
  logic [TGT_W-1:0] tgt_d;
  logic [CTR_W-1:0] ctr_d;

  always_comb begin
    wr_en   = 1'b0;
    valid_d = valid_q[up_idx];
    tag_d   = tag_q[up_idx];
    tgt_d   = tgt_q[up_idx];
    ctr_d   = ctr_q[up_idx];
    if (update_en) begin
      if (old_hit) begin
        wr_en = 1'b1;
        if (update_is_branch) begin
          ctr_d = ctr_step(ctr_q[up_idx], update_taken);
          if (update_taken) tgt_d = update_target[ADDR_W-1:2];
        end else begin
          ctr_d = CTR_MAX;
          tgt_d = update_target[ADDR_W-1:2];
        end
      end else if (update_taken) begin
        wr_en   = 1'b1;
        valid_d = 1'b1;
        tag_d   = up_tag;
        tgt_d   = update_target[ADDR_W-1:2];
        ctr_d   = update_is_branch ? CTR_WT : CTR_MAX;
      end
    end
  end

  // Table state; flush only drops valid bits and overrides any same-cycle write
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_RST;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
    end else if (wr_en) begin
      valid_q[up_idx] <= valid_d;
      tag_q[up_idx]   <= tag_d;
      tgt_q[up_idx]   <= tgt_d;
      ctr_q[up_idx]   <= ctr_d;
    end
  end

  // Statistics
  always_comb begin
    hit_cnt_d = pred_hit   ? stat_inc(hit_cnt_q) : hit_cnt_q;
    mis_cnt_d = mispredict ? stat_inc(mis_cnt_q) : mis_cnt_q;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

  assign hit_count        = hit_cnt_q;
  assign mispredict_count = mis_cnt_q;

endmodule
